intsat_pipe: RTL and testbench

Pipelined, multi-channel rounding saturator for the control loop: drops RTRUNC low bits with a selectable rounding mode, then saturates away LTRUNC high bits, producing an OUT_LEN-bit two's-complement result. It sits between wide accumulator/multiplier outputs and narrow DAC/PI-stage inputs. Samples carry a channel tag; the block keeps per-channel saturation statistics and has valid/ready flow control on both sides.

---
 rtl/intsat_pkg.sv | 13 +
 rtl/intsat_round.sv | 41 ++++
 rtl/intsat_pipe.sv | 145 ++++++++++++++
 tb/tb_intsat_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/intsat_pkg.sv
// Shared encodings for the rounding saturator: round-mode selectors and
// the {neg_sat, pos_sat} flag values reported alongside each output sample.
package intsat_pkg;

   localparam logic [1:0] RND_FLOOR     = 2'd0;
   localparam logic [1:0] RND_HALF_UP   = 2'd1;
   localparam logic [1:0] RND_HALF_EVEN = 2'd2;

   localparam logic [1:0] SAT_NONE = 2'b00;
   localparam logic [1:0] SAT_POS  = 2'b01;
   localparam logic [1:0] SAT_NEG  = 2'b10;

endpackage

// File: rtl/intsat_round.sv
// Combinational round-and-shift: drops RTRUNC low bits of a signed sample,
// with the add done one bit wider than the input so it never wraps.
module intsat_round
   import intsat_pkg::*;
#(
   parameter int IN_LEN = 64,
   parameter int RTRUNC = 0
) (
   input  logic signed [IN_LEN-1:0] i_data,
   input  logic        [1:0]        i_mode,
   output logic signed [IN_LEN-RTRUNC:0] o_data
);

   localparam int HSH = (RTRUNC > 0) ? RTRUNC - 1 : 0;
   localparam int LSB = (RTRUNC > 0) ? RTRUNC : 0;
   localparam logic [IN_LEN:0] ONE  = {{IN_LEN{1'b0}}, 1'b1};
   localparam logic [IN_LEN:0] HALF = ONE << HSH;

   // Half-even biases by half-1 and lets the kept LSB break the tie upward.
   function automatic logic [IN_LEN:0] round_bias(input logic [1:0] mode,
                                                  input logic       kept_lsb);
      logic [IN_LEN:0] b;
      b = '0;
      if (RTRUNC > 0) begin
         case (mode)
            RND_HALF_UP:   b = HALF;
            RND_HALF_EVEN: b = HALF - ONE + {{IN_LEN{1'b0}}, kept_lsb};
            default:       b = '0;
         endcase
      end
      return b;
   endfunction

   logic [IN_LEN:0] w_ext;
   logic [IN_LEN:0] w_sum;

   assign w_ext  = {i_data[IN_LEN-1], i_data};
   assign w_sum  = w_ext + round_bias(i_mode, i_data[LSB]);
   assign o_data = w_sum[IN_LEN:RTRUNC];

endmodule

// File: rtl/intsat_pipe.sv
// Two-stage multi-channel rounding saturator with valid/ready flow control
// and per-channel saturation statistics (saturating counters + sticky flags).
module intsat_pipe
   import intsat_pkg::*;
#(
   parameter  int IN_LEN   = 64,
   parameter  int LTRUNC   = 32,
   parameter  int RTRUNC   = 0,
   parameter  int CHANNELS = 1,
   parameter  int CNT_LEN  = 16,
   localparam int OUT_LEN  = IN_LEN - LTRUNC - RTRUNC,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [IN_LEN-1:0]     in_data,
   input  logic        [CH_W-1:0]       in_chan,
   input  logic        [1:0]            round_mode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [OUT_LEN-1:0]    out_data,
   output logic        [CH_W-1:0]       out_chan,
   output logic        [1:0]            out_sat,
   input  logic        [CHANNELS-1:0]   sat_clear,
   output logic        [CHANNELS-1:0]   sat_sticky,
   output logic [CHANNELS*CNT_LEN-1:0]  sat_count
);

   localparam int SH_LEN = IN_LEN + 1 - RTRUNC;
   localparam logic [CNT_LEN-1:0] CNT_MAX = '1;
   localparam logic [CNT_LEN-1:0] CNT_ONE = {{(CNT_LEN-1){1'b0}}, 1'b1};

   // Result packed as {sat flags, data}; in range when the top LTRUNC+2 bits agree.
   function automatic logic [OUT_LEN+1:0] saturate(input logic [SH_LEN-1:0] v);
      logic [LTRUNC+1:0] top;
      top = v[SH_LEN-1:OUT_LEN-1];
      if ((&top) || !(|top))
         return {SAT_NONE, v[OUT_LEN-1:0]};
      else if (v[SH_LEN-1])
         return {SAT_NEG, 1'b1, {(OUT_LEN-1){1'b0}}};
      else
         return {SAT_POS, 1'b0, {(OUT_LEN-1){1'b1}}};
   endfunction

   function automatic logic [CNT_LEN-1:0] cnt_inc(input logic [CNT_LEN-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_ONE;
   endfunction

   logic                     w_en;
   logic signed [SH_LEN-1:0] w_sh;
   logic [OUT_LEN+1:0]       w_sat_res;
   logic                     w_hs_sat;

   logic                     r_vld_p1;
   logic        [SH_LEN-1:0] r_sh_p1;
   logic        [CH_W-1:0]   r_chan_p1;

   logic                     r_vld_p2;
   logic        [OUT_LEN-1:0] r_data_p2;
   logic        [1:0]        r_sat_p2;
   logic        [CH_W-1:0]   r_chan_p2;

   logic [CNT_LEN-1:0]       r_cnt [CHANNELS];
   logic [CHANNELS-1:0]      r_sticky;

   // Whole pipe advances together; in_ready follows out_ready combinationally.
   assign w_en     = !r_vld_p2 || out_ready;
   assign in_ready = w_en;

   intsat_round #(
      .IN_LEN (IN_LEN),
      .RTRUNC (RTRUNC)
   ) u_round (
      .i_data (in_data),
      .i_mode (round_mode),
      .o_data (w_sh)
   );

   // ---- S1: rounded/shifted value ----
   always_ff @(posedge clk) begin
      if (rst)
         r_vld_p1 <= 1'b0;
      else if (w_en)
         r_vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (w_en) begin
         r_sh_p1   <= w_sh;
         r_chan_p1 <= in_chan;
      end
   end

   assign w_sat_res = saturate(r_sh_p1);

   // ---- S2: saturated output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p2  <= 1'b0;
         r_data_p2 <= '0;
         r_sat_p2  <= SAT_NONE;
         r_chan_p2 <= '0;
      end else if (w_en) begin
         r_vld_p2  <= r_vld_p1;
         r_data_p2 <= w_sat_res[OUT_LEN-1:0];
         r_sat_p2  <= w_sat_res[OUT_LEN+1:OUT_LEN];
         r_chan_p2 <= r_chan_p1;
      end
   end

   assign out_valid = r_vld_p2;
   assign out_data  = r_data_p2;
   assign out_sat   = r_sat_p2;
   assign out_chan  = r_chan_p2;

   assign w_hs_sat = r_vld_p2 && out_ready && (r_sat_p2 != SAT_NONE);

   // A counted event on the same cycle as a clear restarts the count at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++)
            r_cnt[k] <= '0;
         r_sticky <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (w_hs_sat && (int'(r_chan_p2) == k)) begin
               r_cnt[k]    <= sat_clear[k] ? CNT_ONE : cnt_inc(r_cnt[k]);
               r_sticky[k] <= 1'b1;
            end else if (sat_clear[k]) begin
               r_cnt[k]    <= '0;
               r_sticky[k] <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
      assign sat_count[g*CNT_LEN +: CNT_LEN] = r_cnt[g];
   end

   assign sat_sticky = r_sticky;

endmodule

// File: tb/tb_intsat_pipe.sv
// Directed bench for intsat_pipe at IN_LEN=16, LTRUNC=4, RTRUNC=4,
// CHANNELS=2, CNT_LEN=4 (8-bit outputs, 4-bit saturating counters).
module tb_intsat_pipe;

   localparam int IN_LEN   = 16;
   localparam int LTRUNC   = 4;
   localparam int RTRUNC   = 4;
   localparam int CHANNELS = 2;
   localparam int CNT_LEN  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [0:0]  in_chan = '0;
   logic [1:0]  round_mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic [0:0]  out_chan;
   logic [1:0]  out_sat;
   logic [1:0]  sat_clear = '0;
   logic [1:0]  sat_sticky;
   logic [7:0]  sat_count;

   int checks = 0;
   int errors = 0;

   intsat_pipe #(
      .IN_LEN   (IN_LEN),
      .LTRUNC   (LTRUNC),
      .RTRUNC   (RTRUNC),
      .CHANNELS (CHANNELS),
      .CNT_LEN  (CNT_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_chan    (in_chan),
      .round_mode (round_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_chan   (out_chan),
      .out_sat    (out_sat),
      .sat_clear  (sat_clear),
      .sat_sticky (sat_sticky),
      .sat_count  (sat_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_one(input string tag, input logic [15:0] d, input logic [1:0] m,
                           input logic c, input logic [7:0] exp_d, input logic [1:0] exp_s);
      in_data = d; round_mode = m; in_chan = c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
      tick();
      chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp_d});
      chk({tag, "_sat"}, {30'd0, out_sat}, {30'd0, exp_s});
      chk({tag, "_chan"}, {31'd0, out_chan}, {31'd0, c});
   endtask

   initial begin
      int acc;
      int outi;
      int nout;
      logic stalled;
      logic [7:0] held;

      // Reset state
      rst = 1'b1; out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_vld", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_sat", {30'd0, out_sat}, 32'd0);
      chk("rst_cnt", {24'd0, sat_count}, 32'd0);
      chk("rst_sticky", {30'd0, sat_sticky}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_inrdy", {31'd0, in_ready}, 32'd1);

      // Directed rounding/saturation vectors
      send_one("v0123_m0", 16'h0123, 2'd0, 1'b0, 8'h12, 2'b00);
      send_one("v7ff8_m1", 16'h7FF8, 2'd1, 1'b0, 8'h7F, 2'b01);
      send_one("v8000_m0", 16'h8000, 2'd0, 1'b0, 8'h80, 2'b10);
      send_one("v8000_m3", 16'h8000, 2'd3, 1'b0, 8'h80, 2'b10);
      send_one("vfff8_m0", 16'hFFF8, 2'd0, 1'b0, 8'hFF, 2'b00);
      send_one("vfff8_m1", 16'hFFF8, 2'd1, 1'b0, 8'h00, 2'b00);
      send_one("v0018_m2", 16'h0018, 2'd2, 1'b0, 8'h02, 2'b00);
      send_one("v0028_m2", 16'h0028, 2'd2, 1'b0, 8'h02, 2'b00);
      send_one("v0028_m1", 16'h0028, 2'd1, 1'b0, 8'h03, 2'b00);
      send_one("v0028_m3", 16'h0028, 2'd3, 1'b0, 8'h02, 2'b00);
      send_one("v0123_c1", 16'h0123, 2'd0, 1'b1, 8'h12, 2'b00);
      tick(); tick();
      chk("cnt0_after_vec", {28'd0, sat_count[3:0]}, 32'd3);
      chk("cnt1_after_vec", {28'd0, sat_count[7:4]}, 32'd0);
      chk("sticky_after_vec", {30'd0, sat_sticky}, 32'd1);
      sat_clear = 2'b01;
      tick();
      sat_clear = 2'b00;
      chk("clr0_cnt", {28'd0, sat_count[3:0]}, 32'd0);
      chk("clr0_sticky", {30'd0, sat_sticky}, 32'd0);

      // 20 back-to-back saturating samples on channel 1
      nout = 0;
      for (int i = 0; i < 24; i++) begin
         in_valid = (i < 20); in_data = 16'h7FF8; round_mode = 2'd1; in_chan = 1'b1;
         if (out_valid) nout++;
         tick();
      end
      in_valid = 1'b0;
      chk("burst_outputs", nout, 32'd20);
      chk("burst_cnt1", {28'd0, sat_count[7:4]}, 32'd15);
      chk("burst_cnt0", {28'd0, sat_count[3:0]}, 32'd0);
      chk("burst_sticky", {30'd0, sat_sticky}, 32'd2);

      // Clear coincident with a counted handshake: event wins
      send_one("coinc", 16'h7FF8, 2'd1, 1'b1, 8'h7F, 2'b01);
      sat_clear = 2'b10;
      tick();
      sat_clear = 2'b00;
      chk("coinc_cnt1", {28'd0, sat_count[7:4]}, 32'd1);
      chk("coinc_sticky", {30'd0, sat_sticky}, 32'd2);
      sat_clear = 2'b10;
      tick();
      sat_clear = 2'b00;
      chk("clr1_cnt", {28'd0, sat_count[7:4]}, 32'd0);
      chk("clr1_sticky", {30'd0, sat_sticky}, 32'd0);

      // Backpressure: only two samples fit while out_ready is low
      out_ready = 1'b0; acc = 0; round_mode = 2'd0; in_chan = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_data = 16'(16 * (acc + 1)); in_valid = 1'b1;
         if (in_ready) acc++;
         tick();
      end
      chk("bp_accepted", acc, 32'd2);
      chk("bp_inrdy", {31'd0, in_ready}, 32'd0);
      chk("bp_head", {24'd0, out_data}, 32'd1);
      outi = 0; stalled = 1'b0; held = '0;
      for (int c = 0; c < 300 && outi < 5; c++) begin
         if (stalled) begin
            chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, out_data}, {24'd0, held});
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid = (acc < 5);
         in_data = 16'(16 * (acc + 1));
         #1;
         if (in_valid && in_ready) acc++;
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            chk("bp_order", {24'd0, out_data}, outi + 1);
            outi++;
         end else if (out_valid) begin
            stalled = 1'b1;
            held = out_data;
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_all_out", outi, 32'd5);
      tick(); tick();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Reset with two samples in flight
      send_one("pre_rst", 16'h8000, 2'd0, 1'b0, 8'h80, 2'b10);
      tick();
      chk("pre_rst_cnt0", {28'd0, sat_count[3:0]}, 32'd1);
      out_ready = 1'b0;
      in_data = 16'h7FF8; round_mode = 2'd1; in_chan = 1'b0; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      chk("inflight_vld", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data", {24'd0, out_data}, 32'd0);
      chk("mid_rst_cnt", {24'd0, sat_count}, 32'd0);
      chk("mid_rst_sticky", {30'd0, sat_sticky}, 32'd0);
      rst = 1'b0; out_ready = 1'b1;
      tick();
      chk("post_rst_inrdy", {31'd0, in_ready}, 32'd1);
      nout = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid) nout++;
         tick();
      end
      chk("post_rst_stale", nout, 32'd0);
      chk("post_rst_cnt", {24'd0, sat_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
